// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue-side RAW/WAW hazard tracker for the register-file
// read stage. It keeps one busy bit and one latency countdown per register
// x1..x31. Issue is stalled while a source or destination result is still in
// flight. An operand is flagged as forwardable once its countdown reaches zero.
// A drain (fence) mode holds issue until every entry has been cleared.
//
// Optional feature: define SCOREBOARD_STATS_EN to add the stall_cycles_o and
// raw_stalls_o performance counters.
//
// Ports:
//   clock_i, reset_i          clock, synchronous active-high reset
//   issue_*_i                 instruction presented for issue (sources, dest, latency)
//   wb_valid_i, wb_rd_i       writeback clearing an entry
//   flush_i                   squash all in-flight entries
//   drain_req_i               request fence mode
//   stall_o                   issue blocked this cycle (combinational)
//   fwd_rs1_o, fwd_rs2_o      operand pending but ready in bypass (combinational)
//   drain_done_o              drain complete (combinational, one cycle)
//   busy_mask_o               registered busy bits, bit 0 always 0
//   stall_cycles_o, raw_stalls_o  (SCOREBOARD_STATS_EN only) wrapping counters
module hazard_scoreboard #(
  parameter int LAT_W = 3
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             issue_valid_i,
  input  logic [4:0]       issue_rs1_i,
  input  logic             issue_use_rs1_i,
  input  logic [4:0]       issue_rs2_i,
  input  logic             issue_use_rs2_i,
  input  logic             issue_write_rd_i,
  input  logic [4:0]       issue_rd_i,
  input  logic [LAT_W-1:0] issue_latency_i,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             flush_i,
  input  logic             drain_req_i,
  output logic             stall_o,
  output logic             fwd_rs1_o,
  output logic             fwd_rs2_o,
  output logic             drain_done_o,
  output logic [31:0]      busy_mask_o
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]      stall_cycles_o,
  output logic [31:0]      raw_stalls_o
`endif
);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             busy_q, busy_d;
  logic [31:0][LAT_W-1:0]  cnt_q, cnt_d;

  logic raw1, raw2, waw, stall_int, accept, empty;

  // An entry only blocks while its countdown is non-zero. At zero the result
  // already sits in the bypass network, so dependents forward instead.
  always_comb begin
    raw1      = issue_use_rs1_i && (issue_rs1_i != 5'd0) && busy_q[issue_rs1_i] &&
                (cnt_q[issue_rs1_i] != '0);
    raw2      = issue_use_rs2_i && (issue_rs2_i != 5'd0) && busy_q[issue_rs2_i] &&
                (cnt_q[issue_rs2_i] != '0);
    waw       = issue_write_rd_i && (issue_rd_i != 5'd0) && busy_q[issue_rd_i] &&
                (cnt_q[issue_rd_i] != '0);
    stall_int = issue_valid_i && (raw1 || raw2 || waw || (state_q == DRAIN));
    accept    = issue_valid_i && !stall_int && !flush_i;
    empty     = (busy_q == 32'd0);

    stall_o      = !reset_i && stall_int;
    fwd_rs1_o    = !reset_i && issue_valid_i && issue_use_rs1_i && (issue_rs1_i != 5'd0) &&
                   busy_q[issue_rs1_i] && (cnt_q[issue_rs1_i] == '0);
    fwd_rs2_o    = !reset_i && issue_valid_i && issue_use_rs2_i && (issue_rs2_i != 5'd0) &&
                   busy_q[issue_rs2_i] && (cnt_q[issue_rs2_i] == '0);
    drain_done_o = !reset_i && (state_q == DRAIN) && empty;
    busy_mask_o  = reset_i ? 32'd0 : busy_q;
  end

  // Per-register next state. A new issue overrides a same-cycle writeback to the
  // same tag because the writeback belongs to the older producer.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    for (int r = 1; r < 32; r++) begin
      if (flush_i) begin
        busy_d[r] = 1'b0;
        cnt_d[r]  = '0;
      end else if (accept && issue_write_rd_i && (issue_rd_i == 5'(r))) begin
        busy_d[r] = 1'b1;
        cnt_d[r]  = issue_latency_i;
      end else if (wb_valid_i && (wb_rd_i == 5'(r))) begin
        busy_d[r] = 1'b0;
        cnt_d[r]  = '0;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r]  = cnt_q[r] - 1'b1;
      end
    end
    busy_d[0] = 1'b0;
    cnt_d[0]  = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req_i && !flush_i) state_d = DRAIN;
      DRAIN:   if (empty) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= RUN;
      busy_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q, raw_stalls_q;

  // The counters survive a flush. Only reset clears them.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stall_cycles_q <= '0;
      raw_stalls_q   <= '0;
    end else begin
      if (stall_int) stall_cycles_q <= stall_cycles_q + 32'd1;
      if ((raw1 || raw2) && issue_valid_i && (state_q == RUN))
        raw_stalls_q <= raw_stalls_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign raw_stalls_o   = raw_stalls_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  localparam int LAT_W = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset, issue_valid, issue_use_rs1, issue_use_rs2, issue_write_rd;
  logic [4:0]       issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic [LAT_W-1:0] issue_latency;
  logic             wb_valid, flush, drain_req;
  logic             stall, fwd_rs1, fwd_rs2, drain_done;
  logic [31:0]      busy_mask;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0]      stall_cycles, raw_stalls;
`endif

  hazard_scoreboard #(.LAT_W(LAT_W)) dut (
    .clock_i(clock), .reset_i(reset), .issue_valid_i(issue_valid),
    .issue_rs1_i(issue_rs1), .issue_use_rs1_i(issue_use_rs1),
    .issue_rs2_i(issue_rs2), .issue_use_rs2_i(issue_use_rs2),
    .issue_write_rd_i(issue_write_rd), .issue_rd_i(issue_rd),
    .issue_latency_i(issue_latency), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
    .flush_i(flush), .drain_req_i(drain_req), .stall_o(stall),
    .fwd_rs1_o(fwd_rs1), .fwd_rs2_o(fwd_rs2), .drain_done_o(drain_done),
    .busy_mask_o(busy_mask)
`ifdef SCOREBOARD_STATS_EN
    , .stall_cycles_o(stall_cycles), .raw_stalls_o(raw_stalls)
`endif
  );

  int nvec = 0, nfail = 0;

  // Reference model. Each register has an in-flight flag and the absolute cycle
  // at which its result becomes forwardable.
  logic [31:0] mbusy = '0;
  int          mrdy[32];
  int          cyc = 0;
  bit          mdrain = 0;
  int unsigned msc = 0, mrs = 0;

  function automatic bit pending(input logic [4:0] r);
    return (r != 0) && mbusy[r] && (cyc < mrdy[r]);
  endfunction

  function automatic bit ready(input logic [4:0] r);
    return (r != 0) && mbusy[r] && (cyc >= mrdy[r]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_use_rs1 = 0; issue_use_rs2 = 0; issue_write_rd = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_latency = 0;
    wb_valid = 0; wb_rd = 0; flush = 0; drain_req = 0;
  endtask

  task automatic iss(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2,
                     input bit w, input logic [4:0] rd, input int lat);
    issue_valid = 1; issue_rs1 = rs1; issue_use_rs1 = u1; issue_rs2 = rs2; issue_use_rs2 = u2;
    issue_write_rd = w; issue_rd = rd; issue_latency = LAT_W'(lat);
  endtask

  // Called 1 time unit after a posedge with inputs already applied. It checks
  // mid-cycle, advances the model, and returns 1 unit after the next posedge.
  task automatic tick();
    bit r1, r2, ww, es, e1, e2, edd, acc;
    #4;
    if (reset) begin
      es = 0; e1 = 0; e2 = 0; edd = 0;
      chk("stall", 32'(stall), 0);
      chk("fwd_rs1", 32'(fwd_rs1), 0);
      chk("fwd_rs2", 32'(fwd_rs2), 0);
      chk("drain_done", 32'(drain_done), 0);
      chk("busy_mask", busy_mask, 0);
      mbusy = '0; mdrain = 0; msc = 0; mrs = 0;
    end else begin
      r1  = issue_use_rs1 && pending(issue_rs1);
      r2  = issue_use_rs2 && pending(issue_rs2);
      ww  = issue_write_rd && pending(issue_rd);
      es  = issue_valid && (r1 || r2 || ww || mdrain);
      e1  = issue_valid && issue_use_rs1 && ready(issue_rs1);
      e2  = issue_valid && issue_use_rs2 && ready(issue_rs2);
      edd = mdrain && (mbusy == 0);
      chk("stall", 32'(stall), 32'(es));
      chk("fwd_rs1", 32'(fwd_rs1), 32'(e1));
      chk("fwd_rs2", 32'(fwd_rs2), 32'(e2));
      chk("drain_done", 32'(drain_done), 32'(edd));
      chk("busy_mask", busy_mask, mbusy);
`ifdef SCOREBOARD_STATS_EN
      chk("stall_cycles", stall_cycles, msc);
      chk("raw_stalls", raw_stalls, mrs);
      if (es) msc++;
      if ((r1 || r2) && issue_valid && !mdrain) mrs++;
`endif
      acc = issue_valid && !es && !flush;
      if (flush) mbusy = '0;
      else begin
        if (wb_valid && wb_rd != 0) mbusy[wb_rd] = 0;
        if (acc && issue_write_rd && issue_rd != 0) begin
          mbusy[issue_rd] = 1;
          mrdy[issue_rd]  = cyc + 1 + int'(issue_latency);
        end
      end
      if (!mdrain) begin
        if (drain_req && !flush) mdrain = 1;
      end else if (edd) mdrain = 0;
    end
    @(posedge clock);
    cyc++;
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clock); #1;
    tick(); tick();
    reset = 0;
    tick();

    // RAW: producer x5 with latency 3, then a dependent on rs1
    iss(0, 0, 0, 0, 1, 5, 3); tick();
    iss(5, 1, 0, 0, 0, 0, 0); repeat (5) tick();
    idle(); wb_valid = 1; wb_rd = 5; iss(5, 1, 0, 0, 0, 0, 0); tick();
    idle(); iss(5, 1, 0, 0, 0, 0, 0); tick();

    // x0 is never tracked
    idle(); iss(0, 0, 0, 0, 1, 0, 3); tick();
    iss(0, 1, 0, 1, 0, 0, 0); tick();
    idle(); wb_valid = 1; wb_rd = 0; tick();

    // WAW, then a reissue colliding with a writeback of the same tag
    idle(); iss(0, 0, 0, 0, 1, 7, 2); tick();
    iss(0, 0, 0, 0, 1, 7, 4); tick(); tick();
    wb_valid = 1; wb_rd = 7; tick();
    idle(); iss(7, 1, 0, 0, 0, 0, 0); repeat (5) tick();

    // Flush drops the same-cycle issue
    idle(); iss(0, 0, 0, 0, 1, 3, 5); tick();
    iss(0, 0, 0, 0, 1, 9, 5); tick();
    iss(0, 0, 0, 0, 1, 31, 5); tick();
    iss(0, 0, 0, 0, 1, 4, 2); flush = 1; tick();
    idle(); iss(3, 1, 0, 0, 0, 0, 0); tick();

    // Drain: issue blocked until the last entry is written back
    idle(); iss(0, 0, 0, 0, 1, 2, 2); tick();
    idle(); drain_req = 1; tick();
    idle(); iss(1, 1, 0, 0, 1, 6, 1); repeat (3) tick();
    wb_valid = 1; wb_rd = 2; tick();
    wb_valid = 0; tick(); tick(); tick();

    // Reset in the middle of a drain
    idle(); iss(0, 0, 0, 0, 1, 2, 6); tick();
    idle(); drain_req = 1; tick();
    idle(); iss(0, 0, 0, 0, 1, 8, 1); tick();
    reset = 1; tick();
    reset = 0; tick(); tick();

    // Randomized traffic concentrated on a few tags to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      idle();
      reset          = ($urandom_range(0, 499) == 0);
      issue_valid    = ($urandom_range(0, 3) != 0);
      issue_rs1      = 5'($urandom_range(0, 7));
      issue_rs2      = 5'($urandom_range(0, 7));
      issue_rd       = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      issue_use_rs1  = 1'($urandom);
      issue_use_rs2  = 1'($urandom);
      issue_write_rd = 1'($urandom);
      issue_latency  = LAT_W'($urandom);
      wb_valid       = ($urandom_range(0, 4) < 2);
      wb_rd          = 5'($urandom_range(0, 7));
      flush          = ($urandom_range(0, 63) == 0);
      drain_req      = ($urandom_range(0, 31) == 0);
      tick();
    end
    idle(); reset = 0; tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
